enc16_4_stream: RTL and testbench
=================================

// Module: enc16_4_stream
// PURPOSE
//  Sequential 16-to-4 encoder; the inverse of the dec4_16 decode path.
//  Accepts a 16-bit request vector over a valid/ready handshake and returns the
//  index of every set bit as a 4-bit code, one code per output beat, in priority order.
//  Sits between request/flag producers and any logic that consumes binary indices.
// PARAMETERS
//  PRIO_HIGH   0  0: lowest set index first (bit 0 -> code 4'd0); 1: highest index first
//  EMPTY_BEAT  1  1: an all-zero vector emits one beat with out_zero=1; 0: it is dropped silently
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous reset, active-high
//  in_vec     in   16  request vector; bit k encodes to code k
//  in_valid   in   1   in_vec is valid
//  in_ready   out  1   block can accept a vector (IDLE and rst=0)
//  out_code   out  4   binary index of the current set bit
//  out_zero   out  1   current beat reports an all-zero vector (out_code=0)
//  out_last   out  1   final beat for the captured vector
//  out_valid  out  1   out_code, out_zero and out_last are valid
//  out_ready  in   1   downstream accepts the beat
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=IDLE; work register=0; out_valid=0; out_code=0; out_zero=0; out_last=0.
//   - in_ready=0 while rst=1.
//  States: IDLE, EMIT.
//  IDLE:
//   - in_ready=1.
//   - On in_valid&&in_ready: work<=in_vec.
//   - Next state is EMIT, except in_vec==0 with EMPTY_BEAT=0, which stays in IDLE.
//  EMIT:
//   - in_ready=0.
//   - out_valid=1; out_code=priority index of work; out_last=(popcount(work)==1).
//   - For the zero beat: out_zero=1, out_code=0, out_last=1.
//  Beat transfer on out_valid&&out_ready:
//   - Clear the reported bit in work.
//   - If out_last=1, return to IDLE.
//  Stall: while out_valid=1 and out_ready=0, all out_* signals hold stable.
//  Latency: first beat is valid on the cycle after capture. One beat per cycle when out_ready=1.
//  Throughput: vector with N set bits occupies N beats + 1 IDLE cycle (no capture during EMIT).
//  Priority: out_code is always an index whose work bit is 1 (never a stale or cleared index).
//  Width rules: all-ones vector yields 16 beats, codes 0..15 (PRIO_HIGH=0) or 15..0 (PRIO_HIGH=1).
//  Registers: out_code/out_last are derived from the work register only; no combinational path in_vec->out_*.
//  Reset mid-EMIT: the remaining bits are discarded, no further beats are emitted, and IDLE follows.
//  in_valid during EMIT is ignored; the producer holds it until in_ready=1.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> out_valid=0, in_ready=0; after release in_ready=1, out_valid=0.
//  2. in_vec=16'h8421, out_ready=1, PRIO_HIGH=0 -> codes 0,5,10,15 on 4 consecutive cycles;
//     last=1 only on 15; in_ready=1 on the next cycle.
//  3. Same vector, PRIO_HIGH=1 -> codes 15,10,5,0.
//     Toggle out_ready 1,0,0,1... -> each code held stable while stalled; no beat lost or repeated.
//  4. in_vec=0 -> EMPTY_BEAT=1: one beat code=0, zero=1, last=1. EMPTY_BEAT=0: no beat, in_ready=1 next cycle.
//  5. in_vec=16'hFFFF, assert rst after 3 accepted beats (codes 0,1,2) ->
//     out_valid=0 next cycle; a new vector 16'h0040 then yields a single beat code=6, last=1.
//  6. Random vectors with random out_ready over 10k vectors -> beat count == popcount
//     (or 1 for zero), codes strictly ordered per PRIO_HIGH; scoreboard vs. reference model.

Source files
------------

// File: rtl/enc16_4_stream_if.sv
// enc16_4_stream_if: bundles the request-side and beat-side handshake of the
// 16-to-4 stream encoder.
//   in_vec/in_valid/in_ready            : request vector handshake
//   out_code/out_zero/out_last/out_valid : emitted beat
//   out_ready                           : downstream beat acceptance
// Modport slave is the encoder's view; master is the producer/consumer view.
interface enc16_4_stream_if;
  logic [15:0] in_vec;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_code;
  logic        out_zero;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  in_vec, in_valid, out_ready,
    output in_ready, out_code, out_zero, out_last, out_valid
  );

  modport master (
    output in_vec, in_valid, out_ready,
    input  in_ready, out_code, out_zero, out_last, out_valid
  );
endinterface

// File: rtl/enc16_4_stream.sv
// enc16_4_stream: sequential 16-to-4 encoder. Captures a 16-bit request vector
// and emits the index of each set bit as one beat, in priority order.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : enc16_4_stream_if.slave (in_vec/in_valid/in_ready,
//          out_code/out_zero/out_last/out_valid/out_ready)
// Parameters:
//   PRIO_HIGH  : 0 = lowest set index first, 1 = highest set index first
//   EMPTY_BEAT : 1 = all-zero vector emits one out_zero beat, 0 = dropped
module enc16_4_stream #(
  parameter int PRIO_HIGH  = 0,
  parameter int EMPTY_BEAT = 1
) (
  input logic          clk,
  input logic          rst,
  enc16_4_stream_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state, state_nxt;
  logic [15:0] work, work_nxt;
  logic [3:0]  code_r;
  logic        zero_r;
  logic        last_r;
  logic        valid_r;

  function automatic logic [3:0] prio_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    if (PRIO_HIGH != 0) begin
      // Ascending scan: the last hit is the highest set index.
      for (int unsigned i = 0; i < 16; i++)
        if (v[i]) idx = 4'(i);
    end else begin
      // Descending scan: the last hit is the lowest set index.
      for (int unsigned i = 16; i > 0; i--)
        if (v[i-1]) idx = 4'(i - 1);
    end
    return idx;
  endfunction

  // True for zero or exactly one set bit.
  function automatic logic at_most_one(input logic [15:0] v);
    return (v & (v - 16'd1)) == '0;
  endfunction

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          work_nxt = bus.in_vec;
          if ((bus.in_vec != '0) || (EMPTY_BEAT != 0))
            state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          work_nxt = work & ~(16'd1 << code_r);
          if (last_r)
            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat outputs are registered from the next work value, so they always
  // describe the register contents and stay stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      work    <= '0;
      valid_r <= 1'b0;
      code_r  <= '0;
      zero_r  <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      work    <= work_nxt;
      valid_r <= (state_nxt == EMIT);
      if (state_nxt == EMIT) begin
        code_r <= prio_idx(work_nxt);
        zero_r <= (work_nxt == '0);
        last_r <= at_most_one(work_nxt);
      end else begin
        code_r <= '0;
        zero_r <= 1'b0;
        last_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = valid_r;
  assign bus.out_code  = code_r;
  assign bus.out_zero  = zero_r;
  assign bus.out_last  = last_r;

endmodule

// File: tb/tb_enc16_4_stream.sv
// tb_enc16_4_stream: drives two encoder instances in lock-step,
// u0 (PRIO_HIGH=0, EMPTY_BEAT=1) and u1 (PRIO_HIGH=1, EMPTY_BEAT=0).
module tb_enc16_4_stream;

  typedef struct packed {
    logic [3:0] code;
    logic       zero;
    logic       last;
  } beat_t;
  typedef beat_t beat_q[$];

  typedef struct {
    logic [15:0] vec;
    int          mode;
    int          n0;
    int          n1;
    int          f0;
    int          f1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  beat_q got0, got1, exp0, exp1;

  enc16_4_stream_if i0();
  enc16_4_stream_if i1();

  enc16_4_stream #(.PRIO_HIGH(0), .EMPTY_BEAT(1)) u0 (.clk(clk), .rst(rst), .bus(i0));
  enc16_4_stream #(.PRIO_HIGH(1), .EMPTY_BEAT(0)) u1 (.clk(clk), .rst(rst), .bus(i1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model(input logic [15:0] v, input bit ph, input bit eb, output beat_q q);
    int idx;
    beat_t b;
    q = {};
    if (v == 16'h0) begin
      if (eb) begin
        b = '{code: 4'd0, zero: 1'b1, last: 1'b1};
        q.push_back(b);
      end
    end else begin
      for (int k = 0; k < 16; k++) begin
        idx = ph ? 15 - k : k;
        if (v[idx]) begin
          b = '{code: 4'(idx), zero: 1'b0, last: 1'b0};
          q.push_back(b);
        end
      end
      q[q.size()-1].last = 1'b1;
    end
  endtask

  // Beat recorder and stall-stability checker, sampled mid-cycle.
  beat_t prev0, prev1;
  bit    st0, st1;
  always @(negedge clk) begin
    beat_t c0, c1;
    c0 = '{code: i0.out_code, zero: i0.out_zero, last: i0.out_last};
    c1 = '{code: i1.out_code, zero: i1.out_zero, last: i1.out_last};
    if (!mon_en) begin
      st0 = 1'b0;
      st1 = 1'b0;
    end else begin
      if (st0) begin
        chk("stall_valid0", 32'(i0.out_valid), 32'd1);
        chk("stall_beat0", 32'(c0), 32'(prev0));
      end
      if (st1) begin
        chk("stall_valid1", 32'(i1.out_valid), 32'd1);
        chk("stall_beat1", 32'(c1), 32'(prev1));
      end
      if (i0.out_valid && i0.out_ready) got0.push_back(c0);
      if (i1.out_valid && i1.out_ready) got1.push_back(c1);
      st0 = i0.out_valid && !i0.out_ready;
      st1 = i1.out_valid && !i1.out_ready;
      prev0 = c0;
      prev1 = c1;
    end
  end

  task automatic set_ready(input logic r);
    i0.out_ready = r;
    i1.out_ready = r;
  endtask

  task automatic set_in(input logic [15:0] v, input logic val);
    i0.in_vec = v;  i0.in_valid = val;
    i1.in_vec = v;  i1.in_valid = val;
  endtask

  // mode 0: out_ready=1; mode 1: 1,0,0,1 repeating; mode 2: random.
  task automatic run_vec(input logic [15:0] vec, input int mode,
                         output int n0, output int n1, output int f0, output int f1);
    int   cyc;
    logic r;
    model(vec, 1'b0, 1'b1, exp0);
    model(vec, 1'b1, 1'b0, exp1);
    got0 = {};
    got1 = {};
    chk("pre_in_ready0", 32'(i0.in_ready), 32'd1);
    chk("pre_in_ready1", 32'(i1.in_ready), 32'd1);
    set_ready(1'b0);
    set_in(vec, 1'b1);
    mon_en = 1'b1;
    @(posedge clk); #1;
    set_in(~vec, 1'b0);
    chk("first_valid0", 32'(i0.out_valid), 32'd1);
    chk("first_valid1", 32'(i1.out_valid), 32'(vec != 16'h0));
    cyc = 0;
    while ((i0.out_valid || i1.out_valid) && cyc < 200) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      set_ready(r);
      @(posedge clk); #1;
      cyc++;
    end
    mon_en = 1'b0;
    set_ready(1'b0);
    chk("drain_in_budget", 32'(cyc < 200), 32'd1);
    chk("post_in_ready0", 32'(i0.in_ready), 32'd1);
    chk("post_in_ready1", 32'(i1.in_ready), 32'd1);
    chk("beats0", 32'(got0.size()), 32'(exp0.size()));
    chk("beats1", 32'(got1.size()), 32'(exp1.size()));
    for (int k = 0; k < got0.size() && k < exp0.size(); k++)
      chk("beat0", 32'(got0[k]), 32'(exp0[k]));
    for (int k = 0; k < got1.size() && k < exp1.size(); k++)
      chk("beat1", 32'(got1[k]), 32'(exp1[k]));
    n0 = got0.size();
    n1 = got1.size();
    f0 = (n0 > 0) ? int'(got0[0].code) : -1;
    f1 = (n1 > 0) ? int'(got1[0].code) : -1;
  endtask

  vec_t tbl[8];

  initial begin
    int n0, n1, f0, f1;
    logic [15:0] rv;

    tbl[0] = '{vec: 16'h8421, mode: 0, n0: 4,  n1: 4,  f0: 0,  f1: 15};
    tbl[1] = '{vec: 16'h8421, mode: 1, n0: 4,  n1: 4,  f0: 0,  f1: 15};
    tbl[2] = '{vec: 16'h0000, mode: 0, n0: 1,  n1: 0,  f0: 0,  f1: -1};
    tbl[3] = '{vec: 16'hFFFF, mode: 0, n0: 16, n1: 16, f0: 0,  f1: 15};
    tbl[4] = '{vec: 16'h0001, mode: 1, n0: 1,  n1: 1,  f0: 0,  f1: 0};
    tbl[5] = '{vec: 16'h8000, mode: 0, n0: 1,  n1: 1,  f0: 15, f1: 15};
    tbl[6] = '{vec: 16'h5A5A, mode: 1, n0: 8,  n1: 8,  f0: 1,  f1: 14};
    tbl[7] = '{vec: 16'h00F0, mode: 2, n0: 4,  n1: 4,  f0: 4,  f1: 7};

    set_in(16'h0, 1'b0);
    set_ready(1'b0);

    // Reset held for two cycles.
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid0", 32'(i0.out_valid), 32'd0);
    chk("rst_valid1", 32'(i1.out_valid), 32'd0);
    chk("rst_in_ready0", 32'(i0.in_ready), 32'd0);
    chk("rst_in_ready1", 32'(i1.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready0", 32'(i0.in_ready), 32'd1);
    chk("rel_in_ready1", 32'(i1.in_ready), 32'd1);
    chk("rel_outs0", {28'd0, i0.out_valid, i0.out_zero, i0.out_last, 1'b0}, 32'd0);
    chk("rel_code0", 32'(i0.out_code), 32'd0);

    foreach (tbl[t]) begin
      run_vec(tbl[t].vec, tbl[t].mode, n0, n1, f0, f1);
      chk("tbl_n0", 32'(n0), 32'(tbl[t].n0));
      chk("tbl_n1", 32'(n1), 32'(tbl[t].n1));
      chk("tbl_f0", 32'(f0), 32'(tbl[t].f0));
      chk("tbl_f1", 32'(f1), 32'(tbl[t].f1));
    end

    // Reset in the middle of an all-ones vector after three accepted beats.
    set_in(16'hFFFF, 1'b1);
    set_ready(1'b1);
    @(posedge clk); #1;
    set_in(16'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("mid_code0", 32'(i0.out_code), 32'(k));
      chk("mid_code1", 32'(i1.out_code), 32'(15 - k));
      @(posedge clk); #1;
    end
    rst = 1'b1;
    set_ready(1'b0);
    @(posedge clk); #1;
    chk("mid_rst_valid0", 32'(i0.out_valid), 32'd0);
    chk("mid_rst_valid1", 32'(i1.out_valid), 32'd0);
    rst = 1'b0;
    #1;
    run_vec(16'h0040, 0, n0, n1, f0, f1);
    chk("after_rst_n0", 32'(n0), 32'd1);
    chk("after_rst_f0", 32'(f0), 32'd6);
    chk("after_rst_f1", 32'(f1), 32'd6);

    // Next vector held valid throughout EMIT: captured only once IDLE returns.
    set_in(16'h0003, 1'b1);
    set_ready(1'b1);
    @(posedge clk); #1;
    set_in(16'h0100, 1'b1);
    chk("hold_code0_a", 32'(i0.out_code), 32'd0);
    chk("hold_code1_a", 32'(i1.out_code), 32'd1);
    chk("hold_in_ready", 32'(i0.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("hold_code0_b", 32'(i0.out_code), 32'd1);
    chk("hold_last0_b", 32'(i0.out_last), 32'd1);
    chk("hold_code1_b", 32'(i1.out_code), 32'd0);
    @(posedge clk); #1;
    chk("hold_idle_valid", 32'(i0.out_valid), 32'd0);
    chk("hold_idle_ready", 32'(i0.in_ready), 32'd1);
    @(posedge clk); #1;
    set_in(16'h0, 1'b0);
    chk("hold_cap_code0", 32'(i0.out_code), 32'd8);
    chk("hold_cap_code1", 32'(i1.out_code), 32'd8);
    chk("hold_cap_last", 32'(i0.out_last), 32'd1);
    @(posedge clk); #1;
    chk("hold_done_valid", 32'(i0.out_valid), 32'd0);
    set_ready(1'b0);

    // Random vectors with random back-pressure, checked against the model.
    for (int t = 0; t < 600; t++) begin
      rv = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rv = 16'h0;
        1, 2:    rv = rv & 16'($urandom);
        default: ;
      endcase
      run_vec(rv, 2, n0, n1, f0, f1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
